// File: rtl/coin_credit_fsm_pkg.sv
// Shared definitions for the coin credit machine: 7-segment codes, FSM encoding
// and the coin value helper.
package coin_credit_fsm_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    APPLY,
    VEND,
    WAIT_RELEASE
  } state_t;

  function automatic int unsigned coin_value(input int unsigned idx, input int unsigned unit);
    return (idx + 1) * unit;
  endfunction

endpackage

// File: rtl/coin_credit_fsm_seg7.sv
// BCD to active-low 7-segment decoder; codes above 9 blank the digit.
module seg7_decoder
  import coin_credit_fsm_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/coin_credit_fsm.sv
// Single-clock coin acceptor: synchronises and debounces one-hot coin switches,
// accumulates binary credit, vends at PRICE, refunds overflowing coins, drives 4 digits.
module coin_credit_fsm
  import coin_credit_fsm_pkg::*;
#(
  parameter int NUM_COINS       = 4,
  parameter int COIN_UNIT       = 5,
  parameter int PRICE           = 25,
  parameter int CREDIT_MAX      = 45,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int CW             = $clog2(CREDIT_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] coin_sw,
  output logic [CW-1:0]        credit,
  output logic                 coin_accept,
  output logic                 coin_reject,
  output logic                 vend,
  output logic [0:6]           hex_ones,
  output logic [0:6]           hex_tens,
  output logic [0:6]           hex_count,
  output logic [0:6]           hex_pulse
);

  localparam int SW = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  logic [NUM_COINS-1:0] sync1_q, sync_sw_q;
  state_t               state_q, state_d;
  logic [SW-1:0]        sel_q, sel_d, sel_now;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        credit_q, credit_d;
  logic [3:0]           count_q, count_d;
  logic [CW:0]          value_w, sum_w, post_w;
  logic                 fits;
  logic                 sw_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync_sw_q <= '0;
      state_q   <= WAIT_RELEASE;
      sel_q     <= '0;
      cnt_q     <= '0;
      credit_q  <= '0;
      count_q   <= '0;
    end else begin
      sync1_q   <= coin_sw;
      sync_sw_q <= sync1_q;
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      credit_q  <= credit_d;
      count_q   <= count_d;
    end
  end

  // Highest set switch wins when several are pressed together.
  always_comb begin
    sel_now = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (sync_sw_q[i]) sel_now = SW'(i);
    end
  end

  assign sw_any  = |sync_sw_q;
  // Extra bit keeps the overflow comparison from wrapping.
  assign value_w = (CW+1)'(coin_value(32'(sel_q), COIN_UNIT));
  assign sum_w   = {1'b0, credit_q} + value_w;
  assign fits    = (sum_w <= (CW+1)'(CREDIT_MAX));
  assign post_w  = fits ? sum_w : {1'b0, credit_q};

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    credit_d = credit_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (sw_any) begin
          state_d = DEBOUNCE;
          sel_d   = sel_now;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (!sw_any) begin
          state_d = IDLE;
        end else if (sel_now != sel_q) begin
          sel_d = sel_now;
          cnt_d = '0;
        end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      APPLY: begin
        if (fits) begin
          credit_d = sum_w[CW-1:0];
          count_d  = (count_q == 4'd9) ? 4'd0 : count_q + 4'd1;
        end
        cnt_d   = '0;
        state_d = (post_w >= (CW+1)'(PRICE)) ? VEND : WAIT_RELEASE;
      end
      VEND: begin
        credit_d = credit_q - CW'(PRICE);
        cnt_d    = '0;
        state_d  = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (sw_any) begin
          cnt_d = '0;
        end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

  always_comb begin
    coin_accept = (state_q == APPLY) && fits;
    coin_reject = (state_q == APPLY) && !fits;
    vend        = (state_q == VEND);
  end

  logic [3:0] ones_bcd, tens_bcd, pulse_bcd;

  assign credit    = credit_q;
  assign ones_bcd  = 4'(credit_q % CW'(10));
  // Code 4'hF decodes to a blank tens digit.
  assign tens_bcd  = (credit_q < CW'(10)) ? 4'hF : 4'(credit_q / CW'(10));
  assign pulse_bcd = {3'b000, sw_any};

  seg7_decoder u_seg_ones  (.bcd(ones_bcd),  .seg(hex_ones));
  seg7_decoder u_seg_tens  (.bcd(tens_bcd),  .seg(hex_tens));
  seg7_decoder u_seg_count (.bcd(count_q),   .seg(hex_count));
  seg7_decoder u_seg_pulse (.bcd(pulse_bcd), .seg(hex_pulse));

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Directed bench: a default-priced instance plus a PRICE=45 instance that can reach overflow.
module tb_coin_credit_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] coin_sw;

  logic [5:0] credit, credit2;
  logic       acc, rej, vnd, acc2, rej2, vnd2;
  logic [0:6] h_ones, h_tens, h_cnt, h_pul;
  logic [0:6] h2_ones, h2_tens, h2_cnt, h2_pul;

  int total = 0;
  int bad   = 0;
  int n_acc, n_rej, n_vnd, n_acc2, n_rej2, n_vnd2;
  int max_credit = 0;

  always #5 clk = ~clk;

  coin_credit_fsm dut (
    .clk(clk), .reset(reset), .coin_sw(coin_sw), .credit(credit),
    .coin_accept(acc), .coin_reject(rej), .vend(vnd),
    .hex_ones(h_ones), .hex_tens(h_tens), .hex_count(h_cnt), .hex_pulse(h_pul)
  );

  coin_credit_fsm #(.PRICE(45)) dut_hi (
    .clk(clk), .reset(reset), .coin_sw(coin_sw), .credit(credit2),
    .coin_accept(acc2), .coin_reject(rej2), .vend(vnd2),
    .hex_ones(h2_ones), .hex_tens(h2_tens), .hex_count(h2_cnt), .hex_pulse(h2_pul)
  );

  typedef struct {
    logic [3:0] sw;
    int         hold;
    int         acc;
    int         rej;
    int         vnd;
    int         credit;
    int         count;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [0:6] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc)  n_acc++;
    if (rej)  n_rej++;
    if (vnd)  n_vnd++;
    if (acc2) n_acc2++;
    if (rej2) n_rej2++;
    if (vnd2) n_vnd2++;
    if (int'(credit) > max_credit) max_credit = int'(credit);
  endtask

  task automatic clear_counts();
    n_acc = 0; n_rej = 0; n_vnd = 0;
    n_acc2 = 0; n_rej2 = 0; n_vnd2 = 0;
  endtask

  task automatic press(input logic [3:0] sw, input int hold);
    coin_sw = sw;
    repeat (hold) tick();
    coin_sw = 4'b0000;
    repeat (25) tick();
  endtask

  // Reset leaves the FSM in WAIT_RELEASE, so allow it to reach IDLE afterwards.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (20) tick();
  endtask

  task automatic chk_digits(input string name, input logic [0:6] ones, input logic [0:6] tens,
                            input int exp_credit);
    chk({name, "_ones"}, int'(ones), int'(seg_of(exp_credit % 10)));
    chk({name, "_tens"}, int'(tens), int'(exp_credit < 10 ? seg_of(15) : seg_of(exp_credit / 10)));
  endtask

  initial begin
    int n;
    int c;
    int cnt;
    int ev;

    vecs[0] = '{4'b0010, 25, 1, 0, 0, 10, 1};
    vecs[1] = '{4'b0100, 25, 1, 0, 1,  0, 2};
    vecs[2] = '{4'b0001, 10, 0, 0, 0,  0, 2};
    vecs[3] = '{4'b0110, 40, 1, 0, 0, 15, 3};
    vecs[4] = '{4'b1000, 25, 1, 0, 1, 10, 4};
    vecs[5] = '{4'b0011, 25, 1, 0, 0, 20, 5};

    coin_sw = 4'b0000;
    reset   = 1'b1;
    clear_counts();
    tick();
    tick();
    chk("rst_credit", int'(credit), 0);
    chk("rst_accept", int'(acc), 0);
    chk("rst_vend", int'(vnd), 0);
    chk_digits("rst", h_ones, h_tens, 0);
    chk("rst_count", int'(h_cnt), int'(seg_of(0)));
    chk("rst_pulse", int'(h_pul), int'(seg_of(0)));
    reset = 1'b0;
    repeat (20) tick();

    // First press: accept latency is 2 sync + 16 debounce + 1 cycles.
    clear_counts();
    coin_sw = 4'b0001;
    n = 0;
    while (!acc && n < 40) begin
      tick();
      n++;
    end
    chk("accept_latency", n, 19);
    tick();
    chk("first_credit", int'(credit), 5);
    chk("first_no_vend", int'(vnd), 0);
    chk_digits("first", h_ones, h_tens, 5);
    chk("first_count", int'(h_cnt), int'(seg_of(1)));
    repeat (10) tick();
    chk("pulse_held", int'(h_pul), int'(seg_of(1)));
    coin_sw = 4'b0000;
    repeat (25) tick();
    chk("pulse_released", int'(h_pul), int'(seg_of(0)));
    chk("first_single_accept", n_acc, 1);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      clear_counts();
      press(vecs[i].sw, vecs[i].hold);
      chk($sformatf("v%0d_accepts", i), n_acc, vecs[i].acc);
      chk($sformatf("v%0d_rejects", i), n_rej, vecs[i].rej);
      chk($sformatf("v%0d_vends", i), n_vnd, vecs[i].vnd);
      chk($sformatf("v%0d_credit", i), int'(credit), vecs[i].credit);
      chk($sformatf("v%0d_count", i), int'(h_cnt), int'(seg_of(vecs[i].count)));
      chk_digits($sformatf("v%0d", i), h_ones, h_tens, vecs[i].credit);
    end

    // Eleven 5-unit coins: count digit wraps 9 -> 0 -> 1, vends every fifth coin.
    do_reset();
    c = 0;
    cnt = 0;
    for (int k = 0; k < 11; k++) begin
      clear_counts();
      press(4'b0001, 25);
      c += 5;
      ev = 0;
      if (c >= 25) begin
        c -= 25;
        ev = 1;
      end
      cnt = (cnt + 1) % 10;
      chk($sformatf("wrap%0d_credit", k), int'(credit), c);
      chk($sformatf("wrap%0d_vends", k), n_vnd, ev);
      chk($sformatf("wrap%0d_count", k), int'(h_cnt), int'(seg_of(cnt)));
    end

    // Reset in the middle of debouncing a held coin.
    clear_counts();
    coin_sw = 4'b1000;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_credit", int'(credit), 0);
    chk("midrst_count", int'(h_cnt), int'(seg_of(0)));
    repeat (30) tick();
    chk("midrst_held_no_accept", n_acc, 0);
    chk("midrst_pulse", int'(h_pul), int'(seg_of(1)));
    coin_sw = 4'b0000;
    repeat (25) tick();
    press(4'b1000, 25);
    chk("midrst_after_accepts", n_acc, 1);
    chk("midrst_after_credit", int'(credit), 20);

    // Overflow refusal on the PRICE=45 instance; default instance keeps vending.
    do_reset();
    clear_counts();
    press(4'b1000, 25);
    press(4'b1000, 25);
    chk("hi_credit40", int'(credit2), 40);
    chk("lo_credit15", int'(credit), 15);
    chk("lo_vends", n_vnd, 1);
    clear_counts();
    press(4'b0010, 25);
    chk("hi_reject", n_rej2, 1);
    chk("hi_no_accept", n_acc2, 0);
    chk("hi_no_vend", n_vnd2, 0);
    chk("hi_credit_kept", int'(credit2), 40);
    chk_digits("hi", h2_ones, h2_tens, 40);
    chk("hi_count", int'(h2_cnt), int'(seg_of(2)));
    chk("lo_accept", n_acc, 1);
    chk("lo_vend", n_vnd, 1);
    chk("lo_credit0", int'(credit), 0);

    chk("credit_never_above_max", int'(max_credit <= 45), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
